// File: rtl/segre_id_scoreboard.sv
// ID-stage hazard scoreboard.
// Tracks the instructions that have left ID (entry 0 = EX, 1 = MEM, 2 = WB, ...). For every
// source operand of the instruction in ID it picks a bypass source, or it stalls ID when the
// youngest in-flight producer of that register cannot forward its result yet.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset, clears all entries and the stall counter
//   id_valid_i       ID holds a valid instruction
//   id_rf_we_i       ID instruction writes the register file
//   id_waddr_i       ID destination register
//   id_prod_stage_i  first entry index at which the ID result can be forwarded
//   id_raddr_i       source register per operand, operand n at [n*REG_SIZE +: REG_SIZE]
//   id_rd_i          operand n is actually read
//   hold_i           downstream freeze, entries do not advance
//   flush_i          per-entry kill mask
//   stall_o          ID must not issue this cycle
//   issue_o          ID instruction accepted this cycle
//   bypass_sel_o     per operand: 0 = register file, k+1 = forward from entry k
//   stall_cnt_o      saturating count of cycles with stall_o high
module segre_id_scoreboard #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_SIZE   = 5,
  parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        id_valid_i,
  input  logic                        id_rf_we_i,
  input  logic [REG_SIZE-1:0]         id_waddr_i,
  input  logic [SEL_W-1:0]            id_prod_stage_i,
  input  logic [NUM_SRC*REG_SIZE-1:0] id_raddr_i,
  input  logic [NUM_SRC-1:0]          id_rd_i,
  input  logic                        hold_i,
  input  logic [NUM_STAGES-1:0]       flush_i,
  output logic                        stall_o,
  output logic                        issue_o,
  output logic [NUM_SRC*SEL_W-1:0]    bypass_sel_o,
  output logic [31:0]                 stall_cnt_o
);

  logic [NUM_STAGES-1:0]                valid_q, valid_d, valid_live;
  logic [NUM_STAGES-1:0]                we_q, we_d;
  logic [NUM_STAGES-1:0][REG_SIZE-1:0]  waddr_q, waddr_d;
  logic [NUM_STAGES-1:0][SEL_W-1:0]     prod_q, prod_d;
  logic [31:0]                          stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]                   src_stall;
  logic [NUM_SRC-1:0][SEL_W-1:0]        sel;

  // Hazard lookup: scan from the youngest entry, only the first hit decides the operand.
  // Flush does not mask the lookup in the same cycle; it only kills the stored entry.
  always_comb begin
    logic                hit;
    logic [REG_SIZE-1:0] raddr;
    src_stall = '0;
    sel       = '0;
    for (int n = 0; n < int'(NUM_SRC); n++) begin
      hit   = 1'b0;
      raddr = id_raddr_i[n*REG_SIZE +: REG_SIZE];
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        if (!hit && id_rd_i[n] && valid_q[k] && we_q[k] && (waddr_q[k] == raddr) &&
            (raddr != '0)) begin
          hit = 1'b1;
          if (SEL_W'(k) >= prod_q[k]) begin
            sel[n] = SEL_W'(k + 1);
          end else begin
            src_stall[n] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o      = id_valid_i & (|src_stall);
  assign issue_o      = id_valid_i & ~stall_o & ~hold_i;
  assign bypass_sel_o = sel;
  assign stall_cnt_o  = stall_cnt_q;

  assign valid_live = valid_q & ~flush_i;

  always_comb begin
    valid_d = valid_live;
    we_d    = we_q;
    waddr_d = waddr_q;
    prod_d  = prod_q;
    if (!hold_i) begin
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        valid_d[k] = valid_live[k-1];
        we_d[k]    = we_q[k-1];
        waddr_d[k] = waddr_q[k-1];
        prod_d[k]  = prod_q[k-1];
      end
      // A non-issuing ID turns into a bubble; payload fields are don't-care then.
      valid_d[0] = issue_o;
      we_d[0]    = id_rf_we_i;
      waddr_d[0] = id_waddr_i;
      prod_d[0]  = id_prod_stage_i;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      we_q        <= '0;
      waddr_q     <= '0;
      prod_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      prod_q      <= prod_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/segre_id_scoreboard.md
SEGRE_ID_SCOREBOARD -- requirements
Module: segre_id_scoreboard

Interface
REQ-001 Parameter NUM_STAGES, default 3, number of tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB); legal range 2..8.
REQ-002 Parameter NUM_SRC, default 2, number of source operands checked per ID instruction; legal range 1..4.
REQ-003 Parameter REG_SIZE, default 5, register address width.
REQ-004 Parameter SEL_W, default $clog2(NUM_STAGES+1), width of one bypass select.
REQ-005 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 id_valid_i  in  1  ID holds a valid instruction.
REQ-008 id_rf_we_i  in  1  ID instruction writes the register file.
REQ-009 id_waddr_i  in  REG_SIZE  ID destination register.
REQ-010 id_prod_stage_i  in  SEL_W  index of the first entry at which the ID result can be bypassed (0 = end of EX, 1 = end of MEM, ...).
REQ-011 id_raddr_i  in  NUM_SRC*REG_SIZE  source register per operand, operand n at bits [n*REG_SIZE +: REG_SIZE].
REQ-012 id_rd_i  in  NUM_SRC  operand n is actually read.
REQ-013 hold_i  in  1  downstream freeze; pipeline does not advance this cycle.
REQ-014 flush_i  in  NUM_STAGES  per-entry kill mask, bit k invalidates entry k.
REQ-015 stall_o  out  1  ID must not issue this cycle; insert bubble.
REQ-016 issue_o  out  1  ID instruction accepted this cycle.
REQ-017 bypass_sel_o  out  NUM_SRC*SEL_W  per operand: 0 = register file, k+1 = forward from entry k.
REQ-018 stall_cnt_o  out  32  saturating count of cycles with stall_o high.

Function
REQ-019 State: NUM_STAGES entries, each {valid, we, waddr, prod_stage}, entry 0 youngest.
REQ-020 Operand n matches entry k when id_rd_i[n], entry valid, entry we, entry waddr == operand address, and operand address != 0.
REQ-021 For each operand only the youngest matching entry (lowest k) is considered; older matches ignored.
REQ-022 Youngest match with k >= prod_stage: bypass_sel = k+1, no stall from that operand.
REQ-023 Youngest match with k < prod_stage: operand raises stall; bypass_sel = 0.
REQ-024 No match: bypass_sel = 0.
REQ-025 stall_o = id_valid_i AND (any operand stalls); combinational, same cycle as inputs.
REQ-026 issue_o = id_valid_i AND NOT stall_o AND NOT hold_i.
REQ-027 Advance (hold_i low): entry k+1 <= entry k for k = 0..NUM_STAGES-2; oldest entry discarded.
REQ-028 On advance, entry 0 <= ID instruction fields if issue_o, else an invalid bubble (valid = 0).
REQ-029 hold_i high: all entries keep their value; bypass_sel_o and stall_o still evaluated against current entries.
REQ-030 flush_i bit k clears valid of entry k before shift/hold is applied; a flushed entry never matches in the following cycles.
REQ-031 flush_i bit 0 with issue_o in the same cycle: the new ID instruction is still written to entry 0 (flush acts on the old entry only).
REQ-032 Latency: instruction issued in cycle t occupies entry k in cycle t+1+k when hold_i stays low; one extra cycle per hold_i cycle.
REQ-033 stall_cnt_o increments by 1 each cycle stall_o is high, holds at 32'hFFFFFFFF on overflow, counts stall cycles during hold_i too.
REQ-034 prod_stage values >= NUM_STAGES make the result never bypassable; a dependent instruction stalls until the producer leaves the last entry.

Reset
REQ-035 rst_i high at a rising edge: all entry valid bits 0, stall_cnt_o 0; takes priority over hold_i and flush_i.
REQ-036 During and after reset with no issue: stall_o 0, issue_o = id_valid_i AND NOT hold_i, bypass_sel_o all 0.
REQ-037 Reset asserted mid-operation discards all in-flight entries; no bypass selects refer to pre-reset producers.

Verification
REQ-038 Issue ADD x5 (prod_stage 0), next cycle ADD reading x5 on operand 0 -> stall_o 0, bypass_sel[0] = 1.
REQ-039 Issue LW x6 (prod_stage 1), next cycle reader of x6 -> stall_o 1 one cycle, stall_cnt_o 1; following cycle bypass_sel[0] = 2, issue_o 1.
REQ-040 Writers x7 then x7 in consecutive cycles, reader of x7 -> bypass_sel = 1 (youngest), not 2.
REQ-041 Reader of x0 with in-flight writer of x0 -> bypass_sel 0, stall_o 0.
REQ-042 Producer in entry 0, hold_i high 2 cycles -> entry contents and bypass_sel unchanged; flush_i = 3'b001 then -> dependent reader gets bypass_sel 0.
REQ-043 Fill all entries, assert rst_i one cycle -> next cycle all bypass_sel 0, stall_o 0, stall_cnt_o 0.
